// File: rtl/gpu_pkg.sv
// Encodings shared by the scheduler, decoder and fetcher: core states,
// fetcher states and the program-memory widths.
package gpu_pkg;

  localparam int PC_BITS    = 8;
  localparam int INSTR_BITS = 16;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: combinational lookup port and a
// synchronous fill port. Only valid bits are cleared by reset.
module icache_array #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int LINES     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] lookup_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data
);

  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [DATA_BITS-1:0] data_q [LINES];

  logic [IDX_BITS-1:0] rd_idx, wr_idx;

  assign rd_idx      = lookup_addr[IDX_BITS-1:0];
  assign wr_idx      = wr_addr[IDX_BITS-1:0];
  assign hit         = valid_q[rd_idx] && (tag_q[rd_idx] == lookup_addr[ADDR_BITS-1:IDX_BITS]);
  assign lookup_data = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone gate every hit,
  // which keeps the arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_addr[ADDR_BITS-1:IDX_BITS];
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/fetcher.sv
// Per-core instruction fetch FSM answering the scheduler's FETCH/DECODE handshake.
// Define ICACHE_EN to add a direct-mapped instruction cache in front of memory.
module fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = PC_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = INSTR_BITS,
  parameter int CACHE_LINES           = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  fetcher_state_e                   state_q, state_d;
  logic                             valid_q, valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;

  logic                             cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;
  logic                             fill_en;

  // Fill happens only when the memory response lands; lookup only in IDLE.
  assign fill_en = (state_q == FETCHER_FETCHING) && mem_read_ready;

`ifdef ICACHE_EN
  icache_array #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .LINES     (CACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (current_pc),
    .hit         (cache_hit),
    .lookup_data (cache_data),
    .wr_en       (fill_en),
    .wr_addr     (current_pc),
    .wr_data     (mem_read_data)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{fill_en, CACHE_LINES[0]};
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // NOTE: every _d starts from its _q so no path leaves a value unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    case (state_q)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (cache_hit) begin
            instr_d = cache_data;
            state_d = FETCHER_FETCHED;
          end else begin
            valid_d = 1'b1;
            addr_d  = current_pc;
            state_d = FETCHER_FETCHING;
          end
        end
      end
      FETCHER_FETCHING: begin
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          valid_d = 1'b0;
          state_d = FETCHER_FETCHED;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE) state_d = FETCHER_IDLE;
      end
      default: state_d = FETCHER_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCHER_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  assign fetcher_state    = state_q;
  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign instruction      = instr_q;

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: directed handshake cases plus randomized
// fetches checked against a program-image and cache-occupancy model.
module tb_fetcher;
  import gpu_pkg::*;

  localparam int LINES = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  fetcher #(
    .PROGRAM_MEM_ADDR_BITS (8),
    .PROGRAM_MEM_DATA_BITS (16),
    .CACHE_LINES           (LINES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] prog_mem  [256];
  bit          slot_used [LINES];
  logic [7:0]  slot_pc   [LINES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) slot_used[i] = 1'b0;
  endtask

  // A line holds the most recent miss address that maps onto it.
  function automatic bit model_hit(input logic [7:0] pc);
    bit h;
    h = 1'b0;
`ifdef ICACHE_EN
    h = slot_used[int'(pc) % LINES] && (slot_pc[int'(pc) % LINES] == pc);
`endif
    return h;
  endfunction

  task automatic do_fetch(input logic [7:0] pc, input int waits, input int hold);
    bit hit;
    hit        = model_hit(pc);
    core_state = CORE_FETCH;
    current_pc = pc;
    step();
    core_state = CORE_WAIT;
    if (hit) begin
      check("hit_state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
      check("hit_no_req", 32'(mem_read_valid), 32'd0);
    end else begin
      check("req_state", 32'(fetcher_state), 32'(FETCHER_FETCHING));
      check("req_valid", 32'(mem_read_valid), 32'd1);
      check("req_addr", 32'(mem_read_address), 32'(pc));
      for (int i = 0; i < waits; i++) begin
        mem_read_data = 16'($urandom);
        step();
        check("wait_valid", 32'(mem_read_valid), 32'd1);
        check("wait_addr", 32'(mem_read_address), 32'(pc));
      end
      mem_read_ready = 1'b1;
      mem_read_data  = prog_mem[pc];
      step();
      mem_read_ready = 1'b0;
      mem_read_data  = 16'($urandom);
      check("fill_state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
      check("fill_drop_valid", 32'(mem_read_valid), 32'd0);
      slot_used[int'(pc) % LINES] = 1'b1;
      slot_pc[int'(pc) % LINES]   = pc;
    end
    check("instr", 32'(instruction), 32'(prog_mem[pc]));
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
      check("hold_instr", 32'(instruction), 32'(prog_mem[pc]));
    end
    core_state = CORE_DECODE;
    step();
    check("decode_to_idle", 32'(fetcher_state), 32'(FETCHER_IDLE));
    core_state = CORE_EXECUTE;
    step();
    check("idle_stay", 32'(fetcher_state), 32'(FETCHER_IDLE));
    check("idle_instr", 32'(instruction), 32'(prog_mem[pc]));
  endtask

  initial begin
    reset          = 1'b1;
    core_state     = CORE_IDLE;
    current_pc     = 8'h00;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    for (int i = 0; i < 256; i++) prog_mem[i] = 16'($urandom);
    prog_mem[8'h05] = 16'h3A41;
    prog_mem[8'h15] = 16'h1515;
    model_clear();

    step();
    step();
    check("rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
    check("rst_valid", 32'(mem_read_valid), 32'd0);
    check("rst_addr", 32'(mem_read_address), 32'd0);
    check("rst_instr", 32'(instruction), 32'd0);
    reset = 1'b0;

    core_state = CORE_DECODE;
    step();
    check("idle_ignores_decode", 32'(fetcher_state), 32'(FETCHER_IDLE));

    // Miss with three wait cycles, then refetch of the same PC.
    do_fetch(8'h05, 3, 5);
    do_fetch(8'h05, 1, 2);

    mem_read_ready = 1'b1;
    mem_read_data  = 16'hFFFF;
    step();
    mem_read_ready = 1'b0;
    check("spurious_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
    check("spurious_valid", 32'(mem_read_valid), 32'd0);
    check("spurious_instr", 32'(instruction), 32'h3A41);

    // Reset while a request is outstanding.
    core_state = CORE_FETCH;
    current_pc = 8'h40;
    step();
    check("pre_rst_valid", 32'(mem_read_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    core_state = CORE_IDLE;
    model_clear();
    check("mid_rst_valid", 32'(mem_read_valid), 32'd0);
    check("mid_rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
    check("mid_rst_instr", 32'(instruction), 32'd0);
    step();
    check("post_rst_idle", 32'(fetcher_state), 32'(FETCHER_IDLE));

    // Same-index conflict: every one of these misses.
    do_fetch(8'h05, 2, 1);
    do_fetch(8'h15, 0, 1);
    do_fetch(8'h05, 1, 1);

    for (int n = 0; n < 80; n++) begin
      do_fetch(8'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
